// File: rtl/pc_jump_unit_pkg.sv
// Shared definitions for the fetch-stage PC unit: request opcodes, FSM states, field widths.
package pc_jump_unit_pkg;

  localparam int OP_W       = 3;
  localparam int XLEN_DEF   = 32;
  localparam int JIMM_W_DEF = 26;
  localparam int BIMM_W_DEF = 16;

  localparam logic [OP_W-1:0] OP_SEQ = 3'd0;
  localparam logic [OP_W-1:0] OP_BR  = 3'd1;
  localparam logic [OP_W-1:0] OP_J   = 3'd2;
  localparam logic [OP_W-1:0] OP_JAL = 3'd3;
  localparam logic [OP_W-1:0] OP_JR  = 3'd4;
  localparam logic [OP_W-1:0] OP_RET = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_BUBBLE = 2'd2,
    ST_HALT   = 2'd3
  } state_t;

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack; a push when full overwrites the oldest entry.
module pc_ras #(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            push,
  input  logic [XLEN-1:0] push_data,
  input  logic            pop,
  output logic [XLEN-1:0] top,
  output logic            empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [XLEN-1:0] mem [DEPTH];
  logic [AW-1:0]   ptr;
  logic [CW-1:0]   count;
  logic [AW-1:0]   top_idx;

  // ptr names the next free slot, so the top lives one below it
  assign top_idx = ptr - AW'(1);
  assign top     = mem[top_idx];
  assign empty   = (count == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr   <= '0;
      count <= '0;
    end else if (push) begin
      ptr <= ptr + AW'(1);
      if (count != CW'(DEPTH)) count <= count + CW'(1);
    end else if (pop && !empty) begin
      ptr   <= ptr - AW'(1);
      count <= count - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[ptr] <= push_data;
  end

endmodule

// File: rtl/pc_jump_unit.sv
// Fetch PC holder and next-PC select; redirects cost one bubble cycle.
// Optional return-address stack enabled by defining PC_RAS_EN.
module pc_jump_unit
  import pc_jump_unit_pkg::*;
#(
  parameter int              XLEN      = XLEN_DEF,
  parameter int              JIMM_W    = JIMM_W_DEF,
  parameter int              BIMM_W    = BIMM_W_DEF,
  parameter logic [XLEN-1:0] RESET_PC  = '0,
  parameter int              RAS_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pc_ready,
  input  logic              halt,
  input  logic              req_valid,
  input  logic [OP_W-1:0]   req_op,
  input  logic              req_taken,
  input  logic [XLEN-1:0]   req_pc4,
  input  logic [JIMM_W-1:0] req_imm26,
  input  logic [BIMM_W-1:0] req_imm16,
  input  logic [XLEN-1:0]   req_rs,
  output logic [XLEN-1:0]   pc,
  output logic              pc_valid,
  output logic [XLEN-1:0]   link_addr,
  output logic              misalign
);

  if (XLEN <= JIMM_W + 2 || XLEN <= BIMM_W + 2 || RAS_DEPTH < 2 ||
      (RAS_DEPTH & (RAS_DEPTH - 1)) != 0) begin : g_param_check
    $error("pc_jump_unit: illegal parameter combination");
  end

  state_t          state;
  logic            is_br, is_j, is_jal, is_jr, is_ret, redirect;
  logic [XLEN-1:0] br_target, j_target, rs_target, ret_target, target;
  logic            rs_misalign, ret_misalign, misalign_next;

  always_comb begin
    is_br  = 1'b0;
    is_j   = 1'b0;
    is_jal = 1'b0;
    is_jr  = 1'b0;
    is_ret = 1'b0;
    if (req_valid) begin
      case (req_op)
        OP_BR:   is_br  = 1'b1;
        OP_J:    is_j   = 1'b1;
        OP_JAL:  is_jal = 1'b1;
        OP_JR:   is_jr  = 1'b1;
        OP_RET:  is_ret = 1'b1;
        default: ;
      endcase
    end
  end

  assign redirect    = (is_br && req_taken) || is_j || is_jal || is_jr || is_ret;
  assign br_target   = req_pc4 + {{(XLEN-BIMM_W-2){req_imm16[BIMM_W-1]}}, req_imm16, 2'b00};
  assign j_target    = {req_pc4[XLEN-1:JIMM_W+2], req_imm26, 2'b00};
  assign rs_target   = {req_rs[XLEN-1:2], 2'b00};
  assign rs_misalign = |req_rs[1:0];

`ifdef PC_RAS_EN
  logic            ras_empty;
  logic [XLEN-1:0] ras_top;

  pc_ras #(
    .DEPTH (RAS_DEPTH),
    .XLEN  (XLEN)
  ) u_ras (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (is_jal),
    .push_data (req_pc4),
    .pop       (is_ret && !ras_empty),
    .top       (ras_top),
    .empty     (ras_empty)
  );

  // An empty stack falls back to the register operand, which alone can be misaligned
  assign ret_target   = ras_empty ? rs_target : ras_top;
  assign ret_misalign = ras_empty && rs_misalign;
`else
  assign ret_target   = rs_target;
  assign ret_misalign = rs_misalign;
`endif

  always_comb begin
    target        = br_target;
    misalign_next = 1'b0;
    if (is_j || is_jal) begin
      target = j_target;
    end else if (is_jr) begin
      target        = rs_target;
      misalign_next = rs_misalign;
    end else if (is_ret) begin
      target        = ret_target;
      misalign_next = ret_misalign;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc        <= RESET_PC;
      pc_valid  <= 1'b0;
      link_addr <= '0;
      misalign  <= 1'b0;
      state     <= ST_IDLE;
    end else begin
      misalign <= misalign_next;
      if (is_jal) link_addr <= req_pc4;
      // A redirect discards any unaccepted pc, independent of pc_ready
      if (redirect) begin
        pc       <= target;
        pc_valid <= 1'b0;
        state    <= halt ? ST_HALT : ST_BUBBLE;
      end else begin
        case (state)
          ST_IDLE, ST_BUBBLE: begin
            state    <= halt ? ST_HALT : ST_RUN;
            pc_valid <= !halt;
          end
          ST_RUN: begin
            if (halt) begin
              state    <= ST_HALT;
              pc_valid <= 1'b0;
            end else if (pc_valid && pc_ready) begin
              pc <= pc + XLEN'(4);
            end
          end
          ST_HALT: begin
            if (!halt) begin
              state    <= ST_RUN;
              pc_valid <= 1'b1;
            end
          end
          default: begin
            state    <= ST_IDLE;
            pc_valid <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pc_jump_unit.sv
// Table-driven scoreboard bench for pc_jump_unit; RAS expectations follow PC_RAS_EN.
module tb_pc_jump_unit;

  localparam logic [2:0] SEQ = 3'd0, BR = 3'd1, J = 3'd2, JAL = 3'd3, JR = 3'd4, RET = 3'd5;

  typedef struct {
    logic        rdy;
    logic        hlt;
    logic        vld;
    logic [2:0]  op;
    logic        tkn;
    logic [31:0] pc4;
    logic [25:0] i26;
    logic [15:0] i16;
    logic [31:0] rs;
    logic [31:0] e_pc;
    logic        e_vld;
    logic        e_mis;
    logic [31:0] e_link;
  } vec_t;

  typedef struct {
    logic [31:0] pc;
    logic        vld;
    logic        mis;
    logic [31:0] link;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pc_ready, halt, req_valid, req_taken;
  logic [2:0]  req_op;
  logic [31:0] req_pc4, req_rs;
  logic [25:0] req_imm26;
  logic [15:0] req_imm16;
  logic [31:0] pc, link_addr;
  logic        pc_valid, misalign;

  int   n_chk = 0;
  int   n_bad = 0;
  int   step_no = 0;
  exp_t sb[$];
  vec_t tbl[28];
  vec_t seq_v[7];

  pc_jump_unit dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .pc_ready  (pc_ready),
    .halt      (halt),
    .req_valid (req_valid),
    .req_op    (req_op),
    .req_taken (req_taken),
    .req_pc4   (req_pc4),
    .req_imm26 (req_imm26),
    .req_imm16 (req_imm16),
    .req_rs    (req_rs),
    .pc        (pc),
    .pc_valid  (pc_valid),
    .link_addr (link_addr),
    .misalign  (misalign)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic rdy, input logic hlt, input logic vld,
                              input logic [2:0] op, input logic tkn, input logic [31:0] pc4,
                              input logic [25:0] i26, input logic [15:0] i16,
                              input logic [31:0] rs, input logic [31:0] e_pc,
                              input logic e_vld, input logic e_mis, input logic [31:0] e_link);
    vec_t v;
    v.rdy = rdy; v.hlt = hlt; v.vld = vld; v.op = op; v.tkn = tkn; v.pc4 = pc4;
    v.i26 = i26; v.i16 = i16; v.rs = rs;
    v.e_pc = e_pc; v.e_vld = e_vld; v.e_mis = e_mis; v.e_link = e_link;
    return v;
  endfunction

  function automatic vec_t idle(input logic rdy, input logic hlt, input logic [31:0] e_pc,
                                input logic e_vld, input logic [31:0] e_link);
    return mk(rdy, hlt, 1'b0, SEQ, 1'b0, 32'h0, 26'h0, 16'h0, 32'h0, e_pc, e_vld, 1'b0, e_link);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s step %0d: got 0x%08h expected 0x%08h", nm, step_no, act, exp);
    end
  endtask

  task automatic set_idle();
    pc_ready = 1'b1; halt = 1'b0; req_valid = 1'b0; req_op = SEQ; req_taken = 1'b0;
    req_pc4 = '0; req_imm26 = '0; req_imm16 = '0; req_rs = '0;
  endtask

  // Drive one vector, queue its expectation, clock once, then compare the oldest entry.
  task automatic apply(input vec_t v);
    exp_t e;
    pc_ready = v.rdy; halt = v.hlt; req_valid = v.vld; req_op = v.op; req_taken = v.tkn;
    req_pc4 = v.pc4; req_imm26 = v.i26; req_imm16 = v.i16; req_rs = v.rs;
    e.pc = v.e_pc; e.vld = v.e_vld; e.mis = v.e_mis; e.link = v.e_link;
    sb.push_back(e);
    @(posedge clk);
    #1;
    step_no++;
    if (sb.size() == 0) begin
      n_chk++; n_bad++;
      $display("FAIL scoreboard step %0d: got empty queue expected one entry", step_no);
    end else begin
      e = sb.pop_front();
      chk("pc", pc, e.pc);
      chk("pc_valid", {31'b0, pc_valid}, {31'b0, e.vld});
      chk("misalign", {31'b0, misalign}, {31'b0, e.mis});
      chk("link_addr", link_addr, e.link);
    end
  endtask

  initial begin
    tbl[0]  = idle(1, 0, 32'h0, 1, 32'h0);
    tbl[1]  = idle(1, 0, 32'h4, 1, 32'h0);
    tbl[2]  = idle(1, 0, 32'h8, 1, 32'h0);
    tbl[3]  = idle(0, 0, 32'h8, 1, 32'h0);
    tbl[4]  = idle(0, 0, 32'h8, 1, 32'h0);
    tbl[5]  = idle(0, 0, 32'h8, 1, 32'h0);
    tbl[6]  = idle(1, 0, 32'hC, 1, 32'h0);
    tbl[7]  = mk(1, 0, 1, J,  0, 32'h3000_0010, 26'h38, 16'h0, 32'h0, 32'h3000_00E0, 0, 0, 32'h0);
    tbl[8]  = idle(1, 0, 32'h3000_00E0, 1, 32'h0);
    tbl[9]  = idle(1, 0, 32'h3000_00E4, 1, 32'h0);
    tbl[10] = mk(1, 0, 1, BR, 1, 32'h0000_0100, 26'h0, 16'hFFFE, 32'h0, 32'h0000_00F8, 0, 0, 32'h0);
    tbl[11] = idle(1, 0, 32'h0000_00F8, 1, 32'h0);
    tbl[12] = mk(1, 0, 1, BR, 1, 32'hFFFF_FFFC, 26'h0, 16'h0001, 32'h0, 32'h0, 0, 0, 32'h0);
    tbl[13] = idle(1, 0, 32'h0, 1, 32'h0);
    tbl[14] = mk(1, 0, 1, BR, 0, 32'h0000_0008, 26'h0, 16'h0010, 32'h0, 32'h4, 1, 0, 32'h0);
    tbl[15] = mk(1, 0, 1, SEQ, 0, 32'h0, 26'h0, 16'h0, 32'h0, 32'h8, 1, 0, 32'h0);
    tbl[16] = mk(1, 0, 1, JR, 0, 32'h0, 26'h0, 16'h0, 32'h0000_1003, 32'h1000, 0, 1, 32'h0);
    tbl[17] = idle(1, 0, 32'h1000, 1, 32'h0);
    tbl[18] = idle(1, 1, 32'h1000, 0, 32'h0);
    tbl[19] = idle(1, 1, 32'h1000, 0, 32'h0);
    tbl[20] = idle(1, 0, 32'h1000, 1, 32'h0);
    tbl[21] = mk(1, 1, 1, J,  0, 32'h0000_0004, 26'h100, 16'h0, 32'h0, 32'h400, 0, 0, 32'h0);
    tbl[22] = idle(1, 1, 32'h400, 0, 32'h0);
    tbl[23] = idle(1, 0, 32'h400, 1, 32'h0);
    tbl[24] = mk(1, 0, 1, JAL, 0, 32'h0000_0044, 26'h20, 16'h0, 32'h0, 32'h80, 0, 0, 32'h44);
    tbl[25] = mk(0, 0, 1, JR, 0, 32'h0, 26'h0, 16'h0, 32'h0000_2000, 32'h2000, 0, 0, 32'h44);
    tbl[26] = idle(0, 0, 32'h2000, 1, 32'h44);
    tbl[27] = idle(1, 0, 32'h2004, 1, 32'h44);

    seq_v[0] = idle(1, 0, 32'h0, 1, 32'h0);
    seq_v[1] = mk(1, 0, 1, JAL, 0, 32'h40, 26'h1000, 16'h0, 32'h0, 32'h4000, 0, 0, 32'h40);
    seq_v[2] = mk(1, 0, 1, JAL, 0, 32'h80, 26'h2000, 16'h0, 32'h0, 32'h8000, 0, 0, 32'h80);
`ifdef PC_RAS_EN
    seq_v[3] = mk(1, 0, 1, RET, 0, 32'h0, 26'h0, 16'h0, 32'h300, 32'h80, 0, 0, 32'h80);
    seq_v[4] = mk(1, 0, 1, RET, 0, 32'h0, 26'h0, 16'h0, 32'h300, 32'h40, 0, 0, 32'h80);
`else
    seq_v[3] = mk(1, 0, 1, RET, 0, 32'h0, 26'h0, 16'h0, 32'h300, 32'h300, 0, 0, 32'h80);
    seq_v[4] = mk(1, 0, 1, RET, 0, 32'h0, 26'h0, 16'h0, 32'h300, 32'h300, 0, 0, 32'h80);
`endif
    seq_v[5] = mk(1, 0, 1, RET, 0, 32'h0, 26'h0, 16'h0, 32'h200, 32'h200, 0, 0, 32'h80);
    seq_v[6] = idle(1, 0, 32'h200, 1, 32'h80);

    set_idle();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("reset pc", pc, 32'h0);
    chk("reset pc_valid", {31'b0, pc_valid}, 32'h0);
    chk("reset link_addr", link_addr, 32'h0);
    chk("reset misalign", {31'b0, misalign}, 32'h0);
    rst_n = 1'b1;

    for (int i = 0; i < 28; i++) apply(tbl[i]);

    // Reset asserted in the middle of a redirect bubble
    apply(mk(1, 0, 1, JR, 0, 32'h0, 26'h0, 16'h0, 32'h3000, 32'h3000, 0, 0, 32'h44));
    set_idle();
    #2;
    rst_n = 1'b0;
    #1;
    chk("async reset pc", pc, 32'h0);
    chk("async reset pc_valid", {31'b0, pc_valid}, 32'h0);
    chk("async reset link_addr", link_addr, 32'h0);
    @(posedge clk);
    #1;
    chk("held reset pc_valid", {31'b0, pc_valid}, 32'h0);
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++) apply(seq_v[i]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_chk, n_bad);
    $finish;
  end

endmodule
